// File: rtl/prog_run_sequencer.sv
// Run controller in front of the program counter: launches a program, gates the core,
// counts run cycles, ends on halt (after a drain) or timeout, and hands completion back via Req/Done.
//
// state  | meaning
// IDLE   | waiting for a host request with a valid program index
// LAUNCH | one-cycle Start pulse to reset the PC, core still gated
// RUN    | core enabled, cycle counter advancing
// DRAIN  | core gated after Halt so in-flight writes retire
// DONE   | completion reported, held until the host drops Req
module prog_run_sequencer #(
  parameter int NPROG     = 3,
  parameter int CNT_W     = 16,
  parameter int TIMEOUT   = 4096,
  parameter int DRAIN_CYC = 2
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Req,
  input  logic [1:0]       ProgSel,
  input  logic             Abort,
  input  logic             Halt,
  output logic             Start,
  output logic             CoreEn,
  output logic             Busy,
  output logic             Done,
  output logic             TimedOut,
  output logic             ErrBadSel,
  output logic [1:0]       ProgIdx,
  output logic [CNT_W-1:0] CycleCount
);

  localparam int               DW         = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(TIMEOUT - 1);
  localparam logic [DW-1:0]    DRAIN_LOAD = DW'(DRAIN_CYC - 1);
  localparam logic [2:0]       NPROG_V    = 3'(NPROG);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [DW-1:0]   drain_cnt;
  logic            sel_bad;
  logic            launch;
  logic            bad_pulse;
  logic            bad_hold;
  logic [1:0]      bad_sel;
  logic            timeout_hit;

  assign sel_bad     = ({1'b0, ProgSel} >= NPROG_V);
  assign launch      = (state == S_IDLE) && Req && !sel_bad;
  // A held bad request reports once; it re-arms when Req drops or the index changes.
  assign bad_pulse   = (state == S_IDLE) && Req && sel_bad && !(bad_hold && (ProgSel == bad_sel));
  assign timeout_hit = (CycleCount == CNT_LAST);

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Priority inside RUN: Abort, then Halt, then timeout.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (launch) state_nxt = S_LAUNCH;
      S_LAUNCH: state_nxt = Abort ? S_IDLE : S_RUN;
      S_RUN: begin
        if (Abort)            state_nxt = S_IDLE;
        else if (Halt)        state_nxt = S_DRAIN;
        else if (timeout_hit) state_nxt = S_DONE;
      end
      S_DRAIN: begin
        if (Abort)                state_nxt = S_IDLE;
        else if (drain_cnt == '0) state_nxt = S_DONE;
      end
      S_DONE:   if (!Req) state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    Start  = (state == S_LAUNCH);
    CoreEn = (state == S_RUN);
    Busy   = (state == S_LAUNCH) || (state == S_RUN) || (state == S_DRAIN);
    Done   = (state == S_DONE);
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      ProgIdx    <= '0;
      CycleCount <= '0;
      TimedOut   <= 1'b0;
      drain_cnt  <= '0;
      ErrBadSel  <= 1'b0;
      bad_hold   <= 1'b0;
      bad_sel    <= '0;
    end else begin
      ErrBadSel <= bad_pulse;
      if (bad_pulse) begin
        bad_hold <= 1'b1;
        bad_sel  <= ProgSel;
      end else if (!Req || (ProgSel != bad_sel)) begin
        bad_hold <= 1'b0;
      end

      if (launch) begin
        ProgIdx    <= ProgSel;
        CycleCount <= '0;
        TimedOut   <= 1'b0;
      end

      // The final RUN cycle is counted whichever way the run ends.
      if (state == S_RUN) begin
        if (CycleCount != '1) CycleCount <= CycleCount + 1'b1;
        if (!Abort && !Halt && timeout_hit) TimedOut <= 1'b1;
        if (!Abort && Halt) drain_cnt <= DRAIN_LOAD;
      end

      if ((state == S_DRAIN) && (drain_cnt != '0)) drain_cnt <= drain_cnt - 1'b1;
    end
  end

endmodule

// File: tb/tb_prog_run_sequencer.sv
// Self-checking bench for prog_run_sequencer: directed scenarios plus randomized runs
// compared against an event-level model (which of halt/abort/timeout ends the run, and when).
module tb_prog_run_sequencer;

  localparam int T = 12;
  localparam int D = 2;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        Req;
  logic [1:0]  ProgSel;
  logic        Abort;
  logic        Halt;
  logic        Start;
  logic        CoreEn;
  logic        Busy;
  logic        Done;
  logic        TimedOut;
  logic        ErrBadSel;
  logic [1:0]  ProgIdx;
  logic [15:0] CycleCount;

  int checks = 0;
  int errors = 0;

  prog_run_sequencer #(
    .NPROG(3),
    .CNT_W(16),
    .TIMEOUT(T),
    .DRAIN_CYC(D)
  ) dut (
    .Clk(Clk),
    .Reset(Reset),
    .Req(Req),
    .ProgSel(ProgSel),
    .Abort(Abort),
    .Halt(Halt),
    .Start(Start),
    .CoreEn(CoreEn),
    .Busy(Busy),
    .Done(Done),
    .TimedOut(TimedOut),
    .ErrBadSel(ErrBadSel),
    .ProgIdx(ProgIdx),
    .CycleCount(CycleCount)
  );

  always #5 Clk = ~Clk;

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // h: RUN cycle (1-based) carrying Halt, 0 = none.
  // a: busy cycle carrying Abort (0 = LAUNCH, 1.. = RUN then DRAIN), -1 = none.
  task automatic do_run(input int sel, input int h, input int a, input bit drop_req);
    int  he, run_end, busy_nat, exp_busy, exp_cc;
    bit  halted, aborted;
    int  idx, busy_cnt, core_cnt, start_cnt;
    he       = (h >= 1) ? h : 100000;
    halted   = (he <= T);
    run_end  = halted ? he : T;
    busy_nat = halted ? he + D : T;
    aborted  = (a >= 0) && (a <= busy_nat);
    exp_busy = aborted ? a : busy_nat;
    exp_cc   = aborted ? ((a < run_end) ? a : run_end) : run_end;

    ProgSel = 2'(sel);
    Req     = 1'b1;
    Halt    = 1'b0;
    Abort   = 1'b0;
    step();
    chk("launch_start", {31'b0, Start}, 1);
    chk("launch_coreen", {31'b0, CoreEn}, 0);
    chk("launch_busy", {31'b0, Busy}, 1);
    if (a == 0) begin
      Abort = 1'b1;
      Req   = 1'b0;
    end
    step();
    Abort     = 1'b0;
    start_cnt = 0;
    busy_cnt  = 0;
    core_cnt  = 0;
    idx       = 1;
    while (Busy && idx < 500) begin
      busy_cnt++;
      start_cnt += int'(Start);
      if (CoreEn) begin
        chk("run_count", {16'b0, CycleCount}, 32'(core_cnt));
        core_cnt++;
      end
      Halt  = (idx == h);
      Abort = (idx == a);
      if (idx == a || (drop_req && idx == 2)) Req = 1'b0;
      step();
      idx++;
    end
    Halt  = 1'b0;
    Abort = 1'b0;
    chk("busy_cycles", 32'(busy_cnt), 32'(exp_busy));
    chk("coreen_cycles", 32'(core_cnt), 32'(exp_cc));
    chk("extra_start", 32'(start_cnt), 0);
    chk("cycle_count", {16'b0, CycleCount}, 32'(exp_cc));
    chk("done", {31'b0, Done}, {31'b0, !aborted});
    chk("coreen_off", {31'b0, CoreEn}, 0);
    if (!aborted) begin
      chk("timed_out", {31'b0, TimedOut}, {31'b0, !halted});
      chk("prog_idx", {30'b0, ProgIdx}, 32'(sel));
    end
    if (aborted) begin
      step();
      chk("abort_no_done", {31'b0, Done}, 0);
      chk("abort_idle", {31'b0, Busy}, 0);
    end else if (!Req) begin
      step();
      chk("done_drop_early", {31'b0, Done}, 0);
    end else begin
      Abort = 1'b1;
      step();
      chk("done_hold", {31'b0, Done}, 1);
      chk("done_cc_frozen", {16'b0, CycleCount}, 32'(exp_cc));
      Abort = 1'b0;
      Req   = 1'b0;
      step();
      chk("done_release", {31'b0, Done}, 0);
    end
    Req = 1'b0;
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int errs;
    int starts;
    int busys;
    Reset   = 1'b0;
    Req     = 1'b0;
    ProgSel = 2'd0;
    Abort   = 1'b0;
    Halt    = 1'b0;
    #1;
    chk("rst_start", {31'b0, Start}, 0);
    chk("rst_coreen", {31'b0, CoreEn}, 0);
    chk("rst_busy", {31'b0, Busy}, 0);
    chk("rst_done", {31'b0, Done}, 0);
    chk("rst_timedout", {31'b0, TimedOut}, 0);
    chk("rst_errbadsel", {31'b0, ErrBadSel}, 0);
    chk("rst_progidx", {30'b0, ProgIdx}, 0);
    chk("rst_cyclecount", {16'b0, CycleCount}, 0);
    step();
    step();
    Reset = 1'b1;
    step();

    // Directed scenarios
    do_run(1, 10, -1, 0);
    do_run(0, 0, -1, 0);
    do_run(2, 0, 4, 0);
    do_run(1, T, -1, 0);
    do_run(0, 3, 4, 0);
    do_run(2, 0, 0, 0);
    do_run(1, 5, -1, 1);
    do_run(2, 0, T, 0);
    do_run(0, 1, -1, 0);

    // Rejected program index, held request
    ProgSel = 2'd3;
    Req     = 1'b1;
    errs    = 0;
    starts  = 0;
    busys   = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      errs   += int'(ErrBadSel);
      starts += int'(Start);
      busys  += int'(Busy);
    end
    chk("badsel_pulses", 32'(errs), 1);
    chk("badsel_start", 32'(starts), 0);
    chk("badsel_busy", 32'(busys), 0);
    Req = 1'b0;
    step();
    chk("badsel_idle", {31'b0, ErrBadSel}, 0);
    Req = 1'b1;
    step();
    chk("badsel_rearm", {31'b0, ErrBadSel}, 1);
    step();
    chk("badsel_single", {31'b0, ErrBadSel}, 0);
    Req = 1'b0;
    step();

    // Abort while idle is ignored
    Abort = 1'b1;
    step();
    chk("abort_idle_ignored", {31'b0, Busy}, 0);
    Abort = 1'b0;

    // Reset mid-run
    ProgSel = 2'd2;
    Req     = 1'b1;
    step();
    step();
    step();
    step();
    chk("pre_reset_coreen", {31'b0, CoreEn}, 1);
    Reset = 1'b0;
    #1;
    chk("midrst_coreen", {31'b0, CoreEn}, 0);
    chk("midrst_busy", {31'b0, Busy}, 0);
    chk("midrst_start", {31'b0, Start}, 0);
    chk("midrst_cyclecount", {16'b0, CycleCount}, 0);
    chk("midrst_progidx", {30'b0, ProgIdx}, 0);
    Req = 1'b0;
    step();
    Reset = 1'b1;
    step();
    do_run(1, 5, -1, 0);

    // Randomized runs
    for (int n = 0; n < 40; n++) begin
      int sel, h, a;
      bit dr;
      sel = int'($urandom_range(0, 2));
      h   = ($urandom_range(0, 9) < 6) ? int'($urandom_range(1, T + 2)) : 0;
      a   = ($urandom_range(0, 9) < 3) ? int'($urandom_range(0, T + D + 1)) : -1;
      dr  = 1'($urandom_range(0, 1));
      do_run(sel, h, a, dr);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
